// File: rtl/dest_ip_lookup.sv
// Output-port lookup: buffers AXI-Stream packets, matches the destination IPv4 against a programmable table
// and writes the chosen port mask into TUSER of the first beat. Optional DEST_IP_PREFIX_MATCH_EN adds per-entry masks.
module dest_ip_lookup #(
  parameter int         C_S_AXI_DATA_WIDTH   = 32,
  parameter int         C_M_AXIS_DATA_WIDTH  = 256,
  parameter int         C_S_AXIS_DATA_WIDTH  = 256,
  parameter int         C_M_AXIS_TUSER_WIDTH = 128,
  parameter int         C_S_AXIS_TUSER_WIDTH = 128,
  parameter int         DST_PORT_POS         = 24,
  parameter int         DIP_BEAT             = 0,
  parameter int         DIP_LSB              = 16,
  parameter int         TBL_DEPTH_BITS       = 5,
  parameter int         FIFO_DEPTH_BITS      = 3,
  parameter logic [7:0] MISS_OPORT           = 8'h02
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  input  logic                              reset,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     dest_hit_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     dest_miss_count,
  input  logic                              tbl_wr_req,
  input  logic [TBL_DEPTH_BITS-1:0]         tbl_wr_addr,
  input  logic [31:0]                       tbl_wr_ip,
  input  logic [7:0]                        tbl_wr_oport,
  input  logic                              tbl_wr_valid,
`ifdef DEST_IP_PREFIX_MATCH_EN
  input  logic [31:0]                       tbl_wr_mask,
  output logic [31:0]                       tbl_rd_mask,
`endif
  output logic                              tbl_wr_ack,
  input  logic                              tbl_rd_req,
  input  logic [TBL_DEPTH_BITS-1:0]         tbl_rd_addr,
  output logic [31:0]                       tbl_rd_ip,
  output logic [7:0]                        tbl_rd_oport,
  output logic                              tbl_rd_valid,
  output logic                              tbl_rd_ack
);

  localparam int NUM_ENT    = 1 << TBL_DEPTH_BITS;
  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int DW         = C_S_AXIS_DATA_WIDTH;
  localparam int SW         = DW / 8;
  localparam int UW         = C_S_AXIS_TUSER_WIDTH;
  localparam int BW         = DW + SW + UW + 1;
  localparam int CW         = $clog2(DIP_BEAT + 2);
  localparam logic [CW-1:0] DIP_CNT = CW'(DIP_BEAT);
  localparam logic [CW-1:0] SAT_CNT = CW'(DIP_BEAT + 1);
  localparam logic [FIFO_DEPTH_BITS:0] DATA_NF_LVL = (FIFO_DEPTH_BITS + 1)'(FIFO_DEPTH - 1);

  typedef enum logic {ST_HEAD, ST_BODY} state_t;

  logic                       ready_en_q;
  logic [CW-1:0]              beat_cnt_q;
  logic [31:0]                dip;
  logic                       s_fire, lookup_req, short_pkt;
  logic [NUM_ENT-1:0]         match;
  logic [NUM_ENT-1:0][31:0]   ent_ip;
  logic [NUM_ENT-1:0][7:0]    ent_oport;
  logic [NUM_ENT-1:0]         ent_valid;
`ifdef DEST_IP_PREFIX_MATCH_EN
  logic [NUM_ENT-1:0][31:0]   ent_mask;
  logic [31:0]                rd_mask_q;
`endif
  logic [7:0]                 oport_sel;
  logic                       pend_vld_q, pend_hit_q;
  logic [7:0]                 pend_oport_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] hit_cnt_q, miss_cnt_q;
  logic                       wr_ack_q, rd_ack_q, rd_valid_q;
  logic [31:0]                rd_ip_q;
  logic [7:0]                 rd_oport_q;

  logic [BW-1:0]              data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] data_wr_q, data_rd_q;
  logic [FIFO_DEPTH_BITS:0]   data_cnt_q;
  logic [7:0]                 res_mem [4];
  logic [1:0]                 res_wr_q, res_rd_q;
  logic [2:0]                 res_cnt_q;
  logic                       data_push, data_pop, res_pop, data_empty, res_empty;
  logic [BW-1:0]              head;
  logic                       m_tvalid;
  logic [UW-1:0]              m_tuser;
  state_t                     state_q, state_d;

  assign data_empty    = (data_cnt_q == '0);
  assign res_empty     = (res_cnt_q == '0);
  assign S_AXIS_TREADY = ready_en_q && (data_cnt_q < DATA_NF_LVL) && (res_cnt_q < 3'd3);
  assign s_fire        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign data_push     = s_fire;
  assign dip           = S_AXIS_TDATA[DIP_LSB +: 32];
  assign lookup_req    = s_fire && (beat_cnt_q == DIP_CNT);
  // A packet that ends before its IP beat still needs a result so its head can leave.
  assign short_pkt     = s_fire && S_AXIS_TLAST && (beat_cnt_q != DIP_CNT) && (beat_cnt_q != SAT_CNT);

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      ready_en_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (s_fire) begin
        if (S_AXIS_TLAST)               beat_cnt_q <= '0;
        else if (beat_cnt_q != SAT_CNT) beat_cnt_q <= beat_cnt_q + CW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_ENT; gi++) begin : g_ent
    logic [31:0] ip_q;
    logic [7:0]  oport_q;
    logic        valid_q;
`ifdef DEST_IP_PREFIX_MATCH_EN
    logic [31:0] mask_q;
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) mask_q <= '0;
      else if (tbl_wr_req && (tbl_wr_addr == TBL_DEPTH_BITS'(gi))) mask_q <= tbl_wr_mask;
    end
    assign ent_mask[gi] = mask_q;
    assign match[gi]    = valid_q && ((dip & mask_q) == (ip_q & mask_q));
`else
    assign match[gi]    = valid_q && (dip == ip_q);
`endif
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
        ip_q    <= '0;
        oport_q <= '0;
        valid_q <= 1'b0;
      end else if (tbl_wr_req && (tbl_wr_addr == TBL_DEPTH_BITS'(gi))) begin
        ip_q    <= tbl_wr_ip;
        oport_q <= tbl_wr_oport;
        valid_q <= tbl_wr_valid;
      end
    end
    assign ent_ip[gi]    = ip_q;
    assign ent_oport[gi] = oport_q;
    assign ent_valid[gi] = valid_q;
  end

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    oport_sel = MISS_OPORT;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (match[i]) oport_sel = ent_oport[i];
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      pend_vld_q   <= 1'b0;
      pend_hit_q   <= 1'b0;
      pend_oport_q <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      rd_ip_q      <= '0;
      rd_oport_q   <= '0;
      rd_valid_q   <= 1'b0;
`ifdef DEST_IP_PREFIX_MATCH_EN
      rd_mask_q    <= '0;
`endif
    end else begin
      pend_vld_q   <= lookup_req || short_pkt;
      pend_hit_q   <= lookup_req && (|match);
      pend_oport_q <= lookup_req ? oport_sel : MISS_OPORT;
      if (reset) begin
        hit_cnt_q  <= '0;
        miss_cnt_q <= '0;
      end else if (pend_vld_q) begin
        if (pend_hit_q) hit_cnt_q  <= hit_cnt_q + C_S_AXI_DATA_WIDTH'(1);
        else            miss_cnt_q <= miss_cnt_q + C_S_AXI_DATA_WIDTH'(1);
      end
      wr_ack_q <= tbl_wr_req;
      rd_ack_q <= tbl_rd_req;
      if (tbl_rd_req) begin
        rd_ip_q    <= ent_ip[tbl_rd_addr];
        rd_oport_q <= ent_oport[tbl_rd_addr];
        rd_valid_q <= ent_valid[tbl_rd_addr];
`ifdef DEST_IP_PREFIX_MATCH_EN
        rd_mask_q  <= ent_mask[tbl_rd_addr];
`endif
      end
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (data_push)  data_mem[data_wr_q] <= {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST};
    if (pend_vld_q) res_mem[res_wr_q]   <= pend_oport_q;
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      data_wr_q  <= '0;
      data_rd_q  <= '0;
      data_cnt_q <= '0;
      res_wr_q   <= '0;
      res_rd_q   <= '0;
      res_cnt_q  <= '0;
      state_q    <= ST_HEAD;
    end else begin
      state_q <= state_d;
      if (data_push) data_wr_q <= data_wr_q + FIFO_DEPTH_BITS'(1);
      if (data_pop)  data_rd_q <= data_rd_q + FIFO_DEPTH_BITS'(1);
      if (data_push && !data_pop)      data_cnt_q <= data_cnt_q + (FIFO_DEPTH_BITS + 1)'(1);
      else if (!data_push && data_pop) data_cnt_q <= data_cnt_q - (FIFO_DEPTH_BITS + 1)'(1);
      if (pend_vld_q) res_wr_q <= res_wr_q + 2'd1;
      if (res_pop)    res_rd_q <= res_rd_q + 2'd1;
      if (pend_vld_q && !res_pop)      res_cnt_q <= res_cnt_q + 3'd1;
      else if (!pend_vld_q && res_pop) res_cnt_q <= res_cnt_q - 3'd1;
    end
  end

  assign head = data_mem[data_rd_q];

  always_comb begin
    state_d  = state_q;
    m_tvalid = 1'b0;
    m_tuser  = head[UW:1];
    case (state_q)
      ST_HEAD: begin
        m_tvalid = !data_empty && !res_empty;
        m_tuser[DST_PORT_POS +: 8] = res_mem[res_rd_q];
        if (m_tvalid && M_AXIS_TREADY && !head[0]) state_d = ST_BODY;
      end
      ST_BODY: begin
        m_tvalid = !data_empty;
        if (m_tvalid && M_AXIS_TREADY && head[0]) state_d = ST_HEAD;
      end
      default: state_d = ST_HEAD;
    endcase
  end

  assign data_pop        = m_tvalid && M_AXIS_TREADY;
  assign res_pop         = data_pop && (state_q == ST_HEAD);
  assign M_AXIS_TVALID   = m_tvalid;
  assign M_AXIS_TDATA    = head[BW-1 -: DW];
  assign M_AXIS_TSTRB    = head[UW+SW : UW+1];
  assign M_AXIS_TUSER    = m_tuser;
  assign M_AXIS_TLAST    = head[0];
  assign dest_hit_count  = hit_cnt_q;
  assign dest_miss_count = miss_cnt_q;
  assign tbl_wr_ack      = wr_ack_q;
  assign tbl_rd_ack      = rd_ack_q;
  assign tbl_rd_ip       = rd_ip_q;
  assign tbl_rd_oport    = rd_oport_q;
  assign tbl_rd_valid    = rd_valid_q;
`ifdef DEST_IP_PREFIX_MATCH_EN
  assign tbl_rd_mask     = rd_mask_q;
`endif

endmodule

// File: tb/tb_dest_ip_lookup.sv
// Scoreboard bench for dest_ip_lookup: a table model predicts each packet's port mask at issue time,
// a monitor pops expected beats whenever the output handshakes.
module tb_dest_ip_lookup;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam int UW = 128;
  localparam int NE = 32;
  localparam logic [7:0] MISS = 8'h02;

  logic AXI_ACLK = 1'b0;
  always #5 AXI_ACLK = ~AXI_ACLK;

  logic AXI_RESETN;
  logic [DW-1:0] S_AXIS_TDATA, M_AXIS_TDATA;
  logic [SW-1:0] S_AXIS_TSTRB, M_AXIS_TSTRB;
  logic [UW-1:0] S_AXIS_TUSER, M_AXIS_TUSER;
  logic S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
  logic M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
  logic reset;
  logic [31:0] dest_hit_count, dest_miss_count;
  logic tbl_wr_req, tbl_rd_req, tbl_wr_valid, tbl_wr_ack, tbl_rd_ack, tbl_rd_valid;
  logic [4:0] tbl_wr_addr, tbl_rd_addr;
  logic [31:0] tbl_wr_ip, tbl_rd_ip;
  logic [7:0] tbl_wr_oport, tbl_rd_oport;
`ifdef DEST_IP_PREFIX_MATCH_EN
  logic [31:0] tbl_wr_mask, tbl_rd_mask;
`endif

  dest_ip_lookup dut (
    .AXI_ACLK(AXI_ACLK), .AXI_RESETN(AXI_RESETN),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .reset(reset), .dest_hit_count(dest_hit_count), .dest_miss_count(dest_miss_count),
    .tbl_wr_req(tbl_wr_req), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_ip(tbl_wr_ip),
    .tbl_wr_oport(tbl_wr_oport), .tbl_wr_valid(tbl_wr_valid),
`ifdef DEST_IP_PREFIX_MATCH_EN
    .tbl_wr_mask(tbl_wr_mask), .tbl_rd_mask(tbl_rd_mask),
`endif
    .tbl_wr_ack(tbl_wr_ack), .tbl_rd_req(tbl_rd_req), .tbl_rd_addr(tbl_rd_addr),
    .tbl_rd_ip(tbl_rd_ip), .tbl_rd_oport(tbl_rd_oport), .tbl_rd_valid(tbl_rd_valid),
    .tbl_rd_ack(tbl_rd_ack)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  int pkts_out = 0;
  int rdy_mode = 1;  // 0 hold low, 1 always high, 2 random

  logic [31:0] m_ip [NE];
  logic [7:0]  m_oport [NE];
  logic        m_valid [NE];
  logic [31:0] m_mask [NE];
  logic [31:0] cand [6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: first valid entry (by index) whose masked IP equals the masked destination.
  function automatic logic [8:0] ref_lookup(input logic [31:0] dip);
    for (int i = 0; i < NE; i++)
      if (m_valid[i] && (((dip ^ m_ip[i]) & m_mask[i]) == 32'h0)) return {1'b1, m_oport[i]};
    return {1'b0, MISS};
  endfunction

  always begin
    @(posedge AXI_ACLK);
    #1;
    case (rdy_mode)
      0:       M_AXIS_TREADY = 1'b0;
      1:       M_AXIS_TREADY = 1'b1;
      default: M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
    endcase
  end

  initial begin
    forever begin
      @(negedge AXI_ACLK);
      if (AXI_RESETN && M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h expected=none", M_AXIS_TDATA[63:0]);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tdata", 256'(M_AXIS_TDATA), 256'(mon_e.data));
          chk("tstrb", 256'(M_AXIS_TSTRB), 256'(mon_e.strb));
          chk("tuser", 256'(M_AXIS_TUSER), 256'(mon_e.user));
          chk("tlast", 256'(M_AXIS_TLAST), 256'(mon_e.last));
          if (mon_e.last) begin
            pkts_out++;
            $display("pkt %0d out port=%02h", pkts_out, M_AXIS_TUSER[31:24]);
          end
        end
      end
    end
  end

  task automatic drive_beat(input beat_t b);
    bit acc = 0;
    int n = 0;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = b.data;
    S_AXIS_TSTRB  = b.strb;
    S_AXIS_TUSER  = b.user;
    S_AXIS_TLAST  = b.last;
    while (!acc) begin
      @(negedge AXI_ACLK);
      acc = S_AXIS_TREADY;
      @(posedge AXI_ACLK);
      #1;
      n++;
      if (n > 5000) begin
        $display("FAIL s_tready_timeout actual=0 expected=1");
        $fatal(1, "input stalled");
      end
    end
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] dip, input int nbeats);
    logic [8:0] r;
    beat_t b, e;
    r = ref_lookup(dip);
    if (r[8]) exp_hits++;
    else exp_misses++;
    for (int k = 0; k < nbeats; k++) begin
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom();
      for (int w = 0; w < UW / 32; w++) b.user[w*32 +: 32] = $urandom();
      b.strb = $urandom();
      b.last = (k == nbeats - 1);
      if (k == 0) b.data[16 +: 32] = dip;
      e = b;
      if (k == 0) e.user[24 +: 8] = r[7:0];
      exp_q.push_back(e);
      drive_beat(b);
    end
  endtask

  task automatic tbl_write(input int a, input logic [31:0] ip, input logic [7:0] op,
                           input logic v, input logic [31:0] mask);
    tbl_wr_req = 1'b1;
    tbl_wr_addr = 5'(a);
    tbl_wr_ip = ip;
    tbl_wr_oport = op;
    tbl_wr_valid = v;
`ifdef DEST_IP_PREFIX_MATCH_EN
    tbl_wr_mask = mask;
    m_mask[a] = mask;
`else
    m_mask[a] = (mask == 32'h0) ? 32'hFFFFFFFF : 32'hFFFFFFFF;
`endif
    @(posedge AXI_ACLK);
    #1;
    tbl_wr_req = 1'b0;
    m_ip[a] = ip;
    m_oport[a] = op;
    m_valid[a] = v;
    @(negedge AXI_ACLK);
    chk("wr_ack", 256'(tbl_wr_ack), 256'(1));
    @(posedge AXI_ACLK);
    #1;
  endtask

  task automatic tbl_read(input int a);
    tbl_rd_req = 1'b1;
    tbl_rd_addr = 5'(a);
    @(posedge AXI_ACLK);
    #1;
    tbl_rd_req = 1'b0;
    @(negedge AXI_ACLK);
    chk("rd_ack", 256'(tbl_rd_ack), 256'(1));
    chk("rd_ip", 256'(tbl_rd_ip), 256'(m_ip[a]));
    chk("rd_oport", 256'(tbl_rd_oport), 256'(m_oport[a]));
    chk("rd_valid", 256'(tbl_rd_valid), 256'(m_valid[a]));
    @(posedge AXI_ACLK);
    #1;
  endtask

  task automatic drain_and_check_stats();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge AXI_ACLK);
      n++;
    end
    #1;
    repeat (3) @(posedge AXI_ACLK);
    #1;
    chk("drain_remaining", 256'(exp_q.size()), 256'(0));
    chk("hit_count", 256'(dest_hit_count), 256'(exp_hits));
    chk("miss_count", 256'(dest_miss_count), 256'(exp_misses));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    AXI_RESETN = 1'b0;
    S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TSTRB = '0; S_AXIS_TUSER = '0; S_AXIS_TLAST = 1'b0;
    reset = 1'b0;
    tbl_wr_req = 1'b0; tbl_wr_addr = '0; tbl_wr_ip = '0; tbl_wr_oport = '0; tbl_wr_valid = 1'b0;
    tbl_rd_req = 1'b0; tbl_rd_addr = '0;
`ifdef DEST_IP_PREFIX_MATCH_EN
    tbl_wr_mask = '0;
`endif
    for (int i = 0; i < NE; i++) begin
      m_ip[i] = '0; m_oport[i] = '0; m_valid[i] = 1'b0; m_mask[i] = 32'hFFFFFFFF;
    end
    cand[0] = 32'h0A000005; cand[1] = 32'h0A000007; cand[2] = 32'h0A000009;
    cand[3] = 32'hC0A80101; cand[4] = 32'hC0A80102; cand[5] = 32'h0A000063;

    repeat (3) @(negedge AXI_ACLK);
    chk("rst_m_tvalid", 256'(M_AXIS_TVALID), 256'(0));
    chk("rst_s_tready", 256'(S_AXIS_TREADY), 256'(0));
    chk("rst_wr_ack", 256'(tbl_wr_ack), 256'(0));
    chk("rst_rd_ack", 256'(tbl_rd_ack), 256'(0));
    chk("rst_rd_data", 256'({tbl_rd_ip, tbl_rd_oport, tbl_rd_valid}), 256'(0));
    chk("rst_counters", 256'({dest_hit_count, dest_miss_count}), 256'(0));
    @(posedge AXI_ACLK);
    #1;
    AXI_RESETN = 1'b1;
    @(posedge AXI_ACLK);
    @(negedge AXI_ACLK);
    chk("s_tready_after_rst", 256'(S_AXIS_TREADY), 256'(1));
    @(posedge AXI_ACLK);
    #1;
    tbl_read(9);

    // exact hit on entry 3
    tbl_write(3, 32'h0A000005, 8'h04, 1'b1, 32'hFFFFFFFF);
    send_pkt(32'h0A000005, 3);
    drain_and_check_stats();

    // counter clear, then a miss
    reset = 1'b1;
    @(posedge AXI_ACLK);
    #1;
    reset = 1'b0;
    @(negedge AXI_ACLK);
    chk("cnt_clear", 256'({dest_hit_count, dest_miss_count}), 256'(0));
    exp_hits = 0;
    exp_misses = 0;
    @(posedge AXI_ACLK);
    #1;
    send_pkt(32'h0A000009, 2);
    drain_and_check_stats();

    // duplicate entries: lowest index wins, then falls through when cleared
    tbl_write(1, 32'h0A000007, 8'h10, 1'b1, 32'hFFFFFFFF);
    tbl_write(6, 32'h0A000007, 8'h40, 1'b1, 32'hFFFFFFFF);
    send_pkt(32'h0A000007, 1);
    tbl_write(1, 32'h0A000007, 8'h10, 1'b0, 32'hFFFFFFFF);
    send_pkt(32'h0A000007, 2);
    drain_and_check_stats();

    // write then read next cycle; then simultaneous read/write returns the old entry
    tbl_wr_req = 1'b1; tbl_wr_addr = 5'd2; tbl_wr_ip = 32'hC0A80101; tbl_wr_oport = 8'h20; tbl_wr_valid = 1'b1;
    @(posedge AXI_ACLK);
    #1;
    tbl_wr_req = 1'b0;
    m_ip[2] = 32'hC0A80101; m_oport[2] = 8'h20; m_valid[2] = 1'b1;
    tbl_rd_req = 1'b1; tbl_rd_addr = 5'd2;
    @(negedge AXI_ACLK);
    chk("wr_ack_seq", 256'(tbl_wr_ack), 256'(1));
    chk("rd_ack_early", 256'(tbl_rd_ack), 256'(0));
    @(posedge AXI_ACLK);
    #1;
    tbl_rd_req = 1'b0;
    @(negedge AXI_ACLK);
    chk("rd_ack_seq", 256'(tbl_rd_ack), 256'(1));
    chk("rd_ip_seq", 256'(tbl_rd_ip), 256'(32'hC0A80101));
    chk("rd_oport_seq", 256'(tbl_rd_oport), 256'(8'h20));
    @(posedge AXI_ACLK);
    #1;
    tbl_wr_req = 1'b1; tbl_wr_ip = 32'hC0A80102; tbl_wr_oport = 8'h80;
    tbl_rd_req = 1'b1;
    @(posedge AXI_ACLK);
    #1;
    tbl_wr_req = 1'b0; tbl_rd_req = 1'b0;
    @(negedge AXI_ACLK);
    chk("rd_old_on_collide", 256'(tbl_rd_ip), 256'(32'hC0A80101));
    m_ip[2] = 32'hC0A80102; m_oport[2] = 8'h80;
    @(posedge AXI_ACLK);
    #1;
    tbl_read(2);

    // back-pressure: 20 two-beat packets against a stalled output
    rdy_mode = 0;
    @(posedge AXI_ACLK);
    #1;
    fork
      begin
        for (int p = 0; p < 20; p++) send_pkt(cand[$urandom_range(0, 5)], 2);
      end
      begin
        repeat (60) @(posedge AXI_ACLK);
        @(negedge AXI_ACLK);
        chk("bp_s_tready_low", 256'(S_AXIS_TREADY), 256'(0));
        chk("bp_m_tvalid_held", 256'(M_AXIS_TVALID), 256'(1));
        rdy_mode = 2;
      end
    join
    @(posedge AXI_ACLK);
    #1;
    drain_and_check_stats();

    // random lengths, destinations and output throttling
    for (int p = 0; p < 30; p++) begin
      if ($urandom_range(0, 4) == 0) send_pkt($urandom(), $urandom_range(1, 4));
      else send_pkt(cand[$urandom_range(0, 5)], $urandom_range(1, 4));
    end
    drain_and_check_stats();

`ifdef DEST_IP_PREFIX_MATCH_EN
    rdy_mode = 1;
    tbl_write(0, 32'h0A010000, 8'h01, 1'b1, 32'hFFFF0000);
    tbl_write(1, 32'h0A000000, 8'h08, 1'b1, 32'hFF000000);
    send_pkt(32'h0A010203, 2);
    send_pkt(32'h0A090909, 2);
    drain_and_check_stats();
    tbl_read(1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
